// File: rtl/inst_fetch_unit_if.sv
// ============================================================================
// Module   : inst_fetch_unit_if
// Brief    : Instruction-memory, redirect and decode-side signal bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface inst_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [14:0] out_pattern;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, out_pattern,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, out_pattern,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module   : inst_fetch_unit
// Brief    : Single-outstanding instruction fetcher with redirect and output FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  inst_fetch_unit_if.master   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_req_pc;
  logic [31:0]      r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]      r_fifo_inst [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic        w_redirect;
  logic        w_req_valid;
  logic        w_req_fire;
  logic        w_out_valid;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_head_pc;
  logic [31:0] w_head_inst;
  logic        w_unused;

  assign w_redirect  = bus.redirect_valid;
  // rst_n gates the request so it is low throughout reset, not only after the first edge
  assign w_req_valid = rst_n && (r_state == S_REQ) && !w_redirect && (r_count != C_DEPTH);
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;
  assign w_out_valid = (r_count != '0);
  assign w_push      = (r_state == S_WAIT) && bus.imem_rsp_valid && !w_redirect;
  assign w_pop       = w_out_valid && bus.out_ready && !w_redirect;
  assign w_head_pc   = r_fifo_pc[r_rd_ptr];
  assign w_head_inst = r_fifo_inst[r_rd_ptr];
  assign w_unused    = &{1'b0, bus.redirect_pc[1:0]};

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_pc         = w_out_valid ? w_head_pc   : 32'd0;
  assign bus.out_inst       = w_out_valid ? w_head_inst : 32'd0;
  assign bus.out_pattern    = w_out_valid ? {w_head_inst[31:25], w_head_inst[14:12], w_head_inst[6:2]}
                                          : 15'd0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:   if (w_req_fire) w_state_nxt = S_WAIT;
      // A response coinciding with a redirect still retires the request; it is just not pushed
      S_WAIT:  if (bus.imem_rsp_valid) w_state_nxt = S_REQ;
               else if (w_redirect)    w_state_nxt = S_DROP;
      S_DROP:  if (bus.imem_rsp_valid) w_state_nxt = S_REQ;
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= 32'd0;
    end else begin
      if (w_redirect) begin
        r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      end else if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_req_fire) begin
        r_req_pc <= r_fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]   <= 32'd0;
        r_fifo_inst[i] <= 32'd0;
      end
    end else if (w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]   <= r_req_pc;
        r_fifo_inst[r_wr_ptr] <= bus.imem_rsp_data;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// Module   : tb_inst_fetch_unit
// Brief    : Directed self-checking bench for inst_fetch_unit (FIFO_DEPTH = 2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(
    .RESET_PC   (32'h8000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.imem_req_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'd0) begin errors++; $display("FAIL rst_out_pc: got %h want 0", bus.out_pc); end
    checks++; if (bus.out_inst !== 32'd0) begin errors++; $display("FAIL rst_out_inst: got %h want 0", bus.out_inst); end
    checks++; if (bus.out_pattern !== 15'd0) begin errors++; $display("FAIL rst_out_pattern: got %h want 0", bus.out_pattern); end
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_first_req_valid: got %b want 1", bus.imem_req_valid); end
    checks++; if (bus.imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rst_first_req_addr: got %h want 80000000", bus.imem_req_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] d [3];
    d[0] = 32'h0000_0513; d[1] = 32'h00A0_0093; d[2] = 32'h1234_50B7;
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.imem_rsp_valid = 1'b0; #1;
      if (i > 0) begin
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL seq_out_valid[%0d]: got %b want 1", i-1, bus.out_valid); end
        checks++; if (bus.out_pc !== 32'h8000_0000 + 32'(4*(i-1))) begin errors++; $display("FAIL seq_out_pc[%0d]: got %h want %h", i-1, bus.out_pc, 32'h8000_0000 + 32'(4*(i-1))); end
        checks++; if (bus.out_inst !== d[i-1]) begin errors++; $display("FAIL seq_out_inst[%0d]: got %h want %h", i-1, bus.out_inst, d[i-1]); end
      end
      if (i == 1) begin
        checks++; if (bus.out_pattern !== 15'b000000000000100) begin errors++; $display("FAIL seq_pattern: got %b want 000000000000100", bus.out_pattern); end
      end
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL seq_req_valid[%0d]: got %b want 1", i, bus.imem_req_valid); end
      checks++; if (bus.imem_req_addr !== 32'h8000_0000 + 32'(4*i)) begin errors++; $display("FAIL seq_req_addr[%0d]: got %h want %h", i, bus.imem_req_addr, 32'h8000_0000 + 32'(4*i)); end
      @(negedge clk);
      bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = d[i]; #1;
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL seq_wait_req_valid[%0d]: got %b want 0", i, bus.imem_req_valid); end
      @(negedge clk);
    end
    bus.imem_rsp_valid = 1'b0; bus.imem_req_ready = 1'b0; #1;
    checks++; if (bus.out_pc !== 32'h8000_0008) begin errors++; $display("FAIL seq_last_out_pc: got %h want 80000008", bus.out_pc); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b0;
    #1;
    checks++; if (bus.imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL bp_req0_addr: got %h want 80000000", bus.imem_req_addr); end
    @(negedge clk); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0513;
    @(negedge clk); bus.imem_rsp_valid = 1'b0; #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0004) begin errors++; $display("FAIL bp_req1: got valid=%b addr=%h want 1/80000004", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h00A0_0093;
    @(negedge clk); bus.imem_rsp_valid = 1'b0; #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_full_req_valid_a: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.out_inst !== 32'h0000_0513) begin errors++; $display("FAIL bp_hold_inst_a: got %h want 00000513", bus.out_inst); end
    @(negedge clk); #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_full_req_valid_b: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.out_inst !== 32'h0000_0513 || bus.out_pc !== 32'h8000_0000) begin errors++; $display("FAIL bp_hold_head: got pc=%h inst=%h want 80000000/00000513", bus.out_pc, bus.out_inst); end
    @(negedge clk); bus.out_ready = 1'b1; #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle_req_valid: got %b want 0", bus.imem_req_valid); end
    @(negedge clk); bus.out_ready = 1'b0; #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0008) begin errors++; $display("FAIL bp_refill_req: got valid=%b addr=%h want 1/80000008", bus.imem_req_valid, bus.imem_req_addr); end
    checks++; if (bus.out_inst !== 32'h00A0_0093 || bus.out_pc !== 32'h8000_0004) begin errors++; $display("FAIL bp_new_head: got pc=%h inst=%h want 80000004/00a00093", bus.out_pc, bus.out_inst); end
    @(negedge clk); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h1234_50B7; #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_refill_wait: got %b want 0", bus.imem_req_valid); end
    @(negedge clk); bus.imem_rsp_valid = 1'b0; #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_only_one_new_req: got %b want 0", bus.imem_req_valid); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0103; #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_redirect_req_valid: got %b want 0", bus.imem_req_valid); end
    @(negedge clk); bus.redirect_valid = 1'b0; #1;
    checks++; if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rw_drop_idle: got req=%b out=%b want 0/0", bus.imem_req_valid, bus.out_valid); end
    @(negedge clk); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF; #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_drop_rsp_req_valid: got %b want 0", bus.imem_req_valid); end
    @(negedge clk); bus.imem_rsp_valid = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0100) begin errors++; $display("FAIL rw_new_req: got valid=%b addr=%h want 1/80000100", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_out_valid_late: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_redirect_with_rsp();
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b0;
    @(negedge clk); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0513;
    @(negedge clk); bus.imem_rsp_valid = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rr_pre_out_valid: got %b want 1", bus.out_valid); end
    @(negedge clk);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h00A0_0093;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h9000_0000; bus.out_ready = 1'b1; #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rr_req_valid: got %b want 0", bus.imem_req_valid); end
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0; bus.redirect_valid = 1'b0; bus.out_ready = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'd0) begin errors++; $display("FAIL rr_flushed: got out_valid=%b pc=%h want 0/0", bus.out_valid, bus.out_pc); end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h9000_0000) begin errors++; $display("FAIL rr_req_state: got valid=%b addr=%h want 1/90000000", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rr_no_push: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL wr_redirect_req_valid: got %b want 0", bus.imem_req_valid); end
    @(negedge clk); bus.redirect_valid = 1'b0; #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_req_top: got valid=%b addr=%h want 1/fffffffc", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk); bus.imem_req_ready = 1'b1; #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_req_stable: got valid=%b addr=%h want 1/fffffffc", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk); bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0013;
    @(negedge clk); bus.imem_rsp_valid = 1'b0; bus.imem_req_ready = 1'b1; #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_0000) begin errors++; $display("FAIL wr_req_wrapped: got valid=%b addr=%h want 1/00000000", bus.imem_req_valid, bus.imem_req_addr); end
    checks++; if (bus.out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_out_pc: got %h want fffffffc", bus.out_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b0;
    @(negedge clk); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0513;
    @(negedge clk); bus.imem_rsp_valid = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pattern !== 15'b000000000000100) begin errors++; $display("FAIL rm_pre: got valid=%b pattern=%b want 1/000000000000100", bus.out_valid, bus.out_pattern); end
    @(negedge clk);
    rst_n = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_async_valids: got out=%b req=%b want 0/0", bus.out_valid, bus.imem_req_valid); end
    checks++; if (bus.out_pc !== 32'd0 || bus.out_inst !== 32'd0 || bus.out_pattern !== 15'd0) begin errors++; $display("FAIL rm_async_data: got pc=%h inst=%h pat=%h want 0", bus.out_pc, bus.out_inst, bus.out_pattern); end
    @(negedge clk);
    rst_n = 1'b1; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF; #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rm_refetch: got valid=%b addr=%h want 1/80000000", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk); bus.imem_rsp_valid = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_late_rsp_ignored: got %b want 0", bus.out_valid); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_with_rsp();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: PC fetched first after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: number of entries in the fetch output buffer; legal values are 2 and 4.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_addr  out  32  word-aligned fetch address.
REQ-007 imem_req_ready  in  1  memory accepts request; transfer when both valid and ready are high.
REQ-008 imem_rsp_valid  in  1  instruction word returned; no backpressure.
REQ-009 imem_rsp_data  in  32  returned instruction word.
REQ-010 redirect_valid  in  1  one-cycle control-flow redirect (taken jump/branch).
REQ-011 redirect_pc  in  32  redirect target.
REQ-012 out_valid  out  1  fetched instruction available to decode.
REQ-013 out_ready  in  1  decode consumes; transfer when both valid and ready are high.
REQ-014 out_pc  out  32  PC of the head instruction.
REQ-015 out_inst  out  32  head instruction word.
REQ-016 out_pattern  out  15  decode key {inst[31:25], inst[14:12], inst[6:2]}.

Function
REQ-017 The block SHALL allow at most one outstanding imem request.
REQ-018 FSM states SHALL be REQ, WAIT and DROP, with REQ as the reset state.
- REQ -> WAIT on request accept.
- WAIT -> REQ on rsp_valid.
- WAIT -> DROP on redirect without a same-cycle rsp_valid.
- DROP -> REQ on rsp_valid; the response is discarded.
REQ-019 imem_req_valid SHALL be high only in REQ, with no redirect in that cycle, and with free FIFO slots > 0; free slots = FIFO_DEPTH - occupancy.
REQ-020 imem_req_addr SHALL equal the fetch PC and SHALL stay stable while valid is high and ready is low.
REQ-021 On request accept, the fetch PC SHALL advance by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-022 In WAIT, rsp_valid SHALL push {pc_of_request, rsp_data} into the FIFO in the same cycle.
REQ-023 rsp_valid in REQ SHALL be ignored.
REQ-024 Minimum fetch-to-decode latency SHALL be one cycle after the response: the pushed entry is visible at the outputs on the next cycle.
REQ-025 out_valid SHALL equal FIFO non-empty; out_pc, out_inst and out_pattern SHALL reflect the head entry and hold stable while out_valid is high and out_ready is low.
REQ-026 Simultaneous push and pop SHALL keep occupancy unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 When the FIFO is full, no request SHALL issue; overflow is therefore impossible.
REQ-028 redirect_valid SHALL take effect in one cycle:
- flush the FIFO;
- set the fetch PC to {redirect_pc[31:2], 2'b00};
- suppress any same-cycle push and pop;
- deassert imem_req_valid in that cycle.
REQ-029 A redirect in DROP SHALL update the fetch PC and remain in DROP.
REQ-030 A redirect in WAIT with a same-cycle rsp_valid SHALL discard the response and go to REQ.
REQ-031 out_valid SHALL be low in the cycle after a redirect.

Reset
REQ-032 While rst_n is low:
- FSM in REQ;
- fetch PC = RESET_PC;
- FIFO empty;
- imem_req_valid = 0, out_valid = 0;
- out_pc, out_inst and out_pattern = 0.
REQ-033 Assertion of rst_n mid-transaction SHALL abandon any in-flight response.
REQ-034 The first request SHALL be issued in the first cycle after rst_n deasserts.

Verification
REQ-035 Reset then imem_req_ready = 1, 1-cycle response latency, out_ready = 1 -> addresses 8000_0000, 8000_0004, 8000_0008 issued; out_pc in the same order; out_pattern of 32'h0000_0513 equals 15'b000000000000100.
REQ-036 out_ready = 0 with FIFO_DEPTH = 2 -> exactly 2 requests issued, then imem_req_valid stays 0; out_inst is stable; one pop allows exactly one new request.
REQ-037 Redirect to 32'h8000_0103 while in WAIT, response arriving 2 cycles later -> response dropped, next request address 8000_0100, no stale out_valid.
REQ-038 Redirect in the same cycle as rsp_valid and out_ready = 1 -> FIFO empty next cycle, state REQ, no push and no pop counted.
REQ-039 Redirect to 32'hFFFF_FFFC -> requests issued to FFFF_FFFC then 0000_0000.
REQ-040 rst_n pulsed low while in WAIT -> outputs are 0 immediately (asynchronous); the late response is ignored; refetch starts at 8000_0000.
